// File: rtl/ahash_calc.sv
// Average-hash engine: reads an 8x8 image twice (sum for the mean, then
// compare each pixel against it) and publishes a 64-bit hash with its image index.
module ahash_calc #(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 64,
    parameter int IDX_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hash_start,
    input  logic                       idx_clear,
    output logic                       pix_rd_en,
    output logic [$clog2(NUM_PIX)-1:0] pix_addr,
    input  logic [PIX_W-1:0]           pix_data,
    output logic                       busy,
    output logic                       hash_calc_done,
    output logic [NUM_PIX-1:0]         hash_value,
    output logic [IDX_W-1:0]           hash_img_idx
);

    localparam int LOG2  = $clog2(NUM_PIX);
    localparam int SUM_W = PIX_W + LOG2;
    localparam int CNT_W = LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        MEAN,
        CMP,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [SUM_W-1:0]   sum;
    logic [PIX_W-1:0]   mean;
    logic [IDX_W-1:0]   idx;
    logic [NUM_PIX-1:0] shadow;
    logic [NUM_PIX-1:0] shadow_nxt;
    logic               vld_p1;
    logic [LOG2-1:0]    addr_p1;
    logic               last_cycle;

    // Truncating divide by the pixel count.
    function automatic logic [PIX_W-1:0] mean_of(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:LOG2];
    endfunction

    assign busy       = (state != IDLE);
    assign last_cycle = (cnt == CNT_W'(NUM_PIX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hash_start) state_nxt = SUM;
            SUM:     if (last_cycle) state_nxt = MEAN;
            MEAN:    state_nxt = CMP;
            CMP:     if (last_cycle) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data returns one cycle after the strobe; its address travels with it.
    always_comb begin
        shadow_nxt = shadow;
        if (vld_p1) begin
            shadow_nxt[addr_p1] = (pix_data > mean);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            sum            <= '0;
            mean           <= '0;
            idx            <= '0;
            shadow         <= '0;
            vld_p1         <= 1'b0;
            addr_p1        <= '0;
            pix_rd_en      <= 1'b0;
            pix_addr       <= '0;
            hash_calc_done <= 1'b0;
            hash_value     <= '0;
            hash_img_idx   <= '0;
        end else begin
            vld_p1         <= pix_rd_en;
            addr_p1        <= pix_addr;
            hash_calc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (idx_clear) begin
                        idx <= '0;
                    end
                    if (hash_start) begin
                        cnt       <= '0;
                        sum       <= '0;
                        pix_rd_en <= 1'b1;
                        pix_addr  <= '0;
                    end
                end
                SUM, CMP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt < CNT_W'(NUM_PIX - 1)) begin
                        pix_rd_en <= 1'b1;
                        pix_addr  <= pix_addr + LOG2'(1);
                    end else begin
                        pix_rd_en <= 1'b0;
                    end
                    if (state == SUM) begin
                        if (vld_p1) begin
                            sum <= sum + SUM_W'(pix_data);
                        end
                    end else begin
                        shadow <= shadow_nxt;
                        if (last_cycle) begin
                            hash_value     <= shadow_nxt;
                            hash_img_idx   <= idx;
                            idx            <= idx + IDX_W'(1);
                            hash_calc_done <= 1'b1;
                        end
                    end
                end
                MEAN: begin
                    mean      <= mean_of(sum);
                    cnt       <= '0;
                    pix_rd_en <= 1'b1;
                    pix_addr  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahash_calc.sv
// Bench for ahash_calc: image-buffer model, scoreboard of expected hashes
// filled at start time and drained by a monitor on every completion pulse.
module tb_ahash_calc;

    logic        clk = 1'b0;
    logic        reset;
    logic        hash_start;
    logic        idx_clear;
    logic        pix_rd_en;
    logic [5:0]  pix_addr;
    logic [7:0]  pix_data;
    logic        busy;
    logic        hash_calc_done;
    logic [63:0] hash_value;
    logic [15:0] hash_img_idx;

    ahash_calc #(.PIX_W(8), .NUM_PIX(64), .IDX_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .hash_start     (hash_start),
        .idx_clear      (idx_clear),
        .pix_rd_en      (pix_rd_en),
        .pix_addr       (pix_addr),
        .pix_data       (pix_data),
        .busy           (busy),
        .hash_calc_done (hash_calc_done),
        .hash_value     (hash_value),
        .hash_img_idx   (hash_img_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hash;
        logic [15:0] idx;
        int          start;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [64];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    logic [15:0] exp_idx = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pix_rd_en) pix_data <= mem[pix_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_hash();
        int          total = 0;
        int          avg;
        logic [63:0] h = '0;
        foreach (mem[i]) total += int'(mem[i]);
        avg = total / 64;
        foreach (mem[i]) h[i] = (int'(mem[i]) > avg);
        return h;
    endfunction

    // Monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (busy !== 1'b1) rd_cnt = 0;
        else if (pix_rd_en === 1'b1) rd_cnt++;
        if (hash_calc_done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("hash_value", hash_value, e.hash);
                chk("hash_img_idx", 64'(hash_img_idx), 64'(e.idx));
                chk("done_latency", 64'(cyc - e.start), 64'd132);
                chk("rd_en_cycles", 64'(rd_cnt), 64'd128);
            end
        end
    end

    task automatic issue(input bit use_model, input logic [63:0] want, input bit clr);
        exp_t e;
        @(negedge clk);
        hash_start = 1'b1;
        idx_clear  = clr;
        if (clr) exp_idx = 16'd0;
        e.hash  = use_model ? model_hash() : want;
        e.idx   = exp_idx;
        e.start = cyc;
        sb.push_back(e);
        exp_idx = exp_idx + 16'd1;
        @(negedge clk);
        hash_start = 1'b0;
        idx_clear  = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got timeout with %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        int base;
        reset      = 1'b1;
        hash_start = 1'b0;
        idx_clear  = 1'b0;
        foreach (mem[i]) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_en", 64'(pix_rd_en), 64'd0);
        chk("rst_addr", 64'(pix_addr), 64'd0);
        chk("rst_done", 64'(hash_calc_done), 64'd0);
        chk("rst_hash", hash_value, 64'd0);
        chk("rst_idx", 64'(hash_img_idx), 64'd0);

        foreach (mem[i]) mem[i] = 8'd100;
        issue(1'b0, 64'h0, 1'b0);
        wait_done();

        foreach (mem[i]) mem[i] = 8'(4 * i);
        issue(1'b0, 64'hFFFF_FFFF_0000_0000, 1'b0);
        wait_done();

        foreach (mem[i]) mem[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
        issue(1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        wait_done();

        foreach (mem[i]) mem[i] = 8'd255;
        issue(1'b0, 64'h0, 1'b0);
        wait_done();

        // Random images, some clustered tightly around their mean.
        for (int k = 0; k < 6; k++) begin
            base = $urandom_range(1, 254);
            foreach (mem[i]) begin
                if (k % 2 == 0) mem[i] = 8'($urandom_range(0, 255));
                else            mem[i] = 8'(base - 1 + $urandom_range(0, 2));
            end
            issue(1'b1, 64'h0, 1'b0);
            wait_done();
        end

        // Three images from index 0; a stray start mid-SUM must be dropped.
        @(negedge clk);
        idx_clear = 1'b1;
        exp_idx   = 16'd0;
        @(negedge clk);
        idx_clear = 1'b0;
        foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
        issue(1'b1, 64'h0, 1'b0);
        repeat (20) @(negedge clk);
        hash_start = 1'b1;
        @(negedge clk);
        hash_start = 1'b0;
        wait_done();
        for (int k = 0; k < 2; k++) begin
            foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
            issue(1'b1, 64'h0, 1'b0);
            wait_done();
        end

        foreach (mem[i]) mem[i] = 8'(4 * i);
        issue(1'b1, 64'h0, 1'b1);
        wait_done();

        // Abort in the 10th CMP cycle.
        foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
        @(negedge clk);
        hash_start = 1'b1;
        n = cyc;
        @(negedge clk);
        hash_start = 1'b0;
        repeat (75) @(negedge clk);
        chk("pre_abort_busy", 64'(cyc - n), 64'd76);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rd_en", 64'(pix_rd_en), 64'd0);
        chk("abort_hash", hash_value, 64'd0);
        chk("abort_done", 64'(hash_calc_done), 64'd0);
        chk("abort_idx", 64'(hash_img_idx), 64'd0);
        repeat (150) @(negedge clk);
        exp_idx = 16'd0;
        issue(1'b1, 64'h0, 1'b0);
        wait_done();

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahash_calc.md
Name: ahash_calc

Overview:
Perceptual average-hash engine for the image reordering accelerator, directly downstream of the controller's hash_start and upstream of its hash_calc_done.
- On hash_start it reads the buffered 8x8 grayscale image from the image buffer in two passes:
  - pass 1 sums all pixels to get the mean;
  - pass 2 compares each pixel against that mean.
- It delivers a 64-bit hash plus the image index to the reorder stage and pulses hash_calc_done back to the controller.

Parameters:
PIX_W, 8, pixel width in bits
NUM_PIX, 64, pixels per image; fixed power of two, LOG2 = 6, hash width = NUM_PIX
IDX_W, 16, image index width (matches controller num_images)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
hash_start  in  1  one-cycle start pulse from controller
idx_clear  in  1  zero the image index (new batch)
pix_rd_en  out  1  pixel read strobe to image buffer
pix_addr  out  6  pixel address, row-major 0..63
pix_data  in  PIX_W  read data, valid exactly 1 cycle after pix_rd_en
busy  out  1  high in every state except IDLE
hash_calc_done  out  1  one-cycle completion pulse
hash_value  out  NUM_PIX  hash; bit i belongs to pixel address i
hash_img_idx  out  IDX_W  index of the image that hash_value belongs to

Behaviour:
- Reset (synchronous, active-high, takes priority over everything in any state):
  - state IDLE.
  - Outputs: pix_rd_en=0, pix_addr=0, busy=0, hash_calc_done=0, hash_value=0, hash_img_idx=0.
  - Internal: sum=0, mean=0, internal idx counter=0.
- States:
  - IDLE: waits for hash_start.
  - SUM: 65 cycles.
    - Cycles 0..63 assert pix_rd_en with pix_addr = cycle count.
    - Cycles 1..64 add pix_data into sum.
    - sum width PIX_W+LOG2 = 14 bits, so no overflow (max 16320).
    - sum is cleared on entry.
  - MEAN: 1 cycle.
    - mean = sum >> 6 (truncating).
    - pix_rd_en=0.
  - CMP: 65 cycles, same read pattern as SUM.
    - On data cycles, shadow bit[addr] = (pix_data > mean), strict greater-than.
  - DONE: 1 cycle.
    - hash_calc_done=1.
    - hash_value <= shadow register.
    - hash_img_idx <= idx counter, then idx counter increments (wraps at 2^IDX_W).
    - Returns to IDLE.
- Latency: hash_start sampled at edge T -> SUM T+1..T+65, MEAN T+66, CMP T+67..T+131, hash_calc_done high during T+132. Back-to-back start possible at T+133.
- hash_value and hash_img_idx update only in DONE and hold until the next DONE.
- hash_start while busy=1 is ignored (no restart, no queueing).
- idx_clear is honoured only in IDLE.
  - idx_clear with hash_start in the same cycle: clear applies first, so that image gets index 0.
  - idx_clear while busy is ignored.
- pix_addr holds its last value when pix_rd_en=0.
- Reset mid-operation aborts the hash.
  - No hash_calc_done is produced.
  - Index returns to 0.

Test Plan:
- All 64 pixels = 100 -> sum 6400, mean 100, hash_value = 0x0000000000000000 (strict compare), hash_img_idx=0, hash_calc_done exactly 132 cycles after hash_start.
- pixel[i] = 4*i -> sum 8064, mean 126 -> hash_value = 0xFFFFFFFF00000000. Also check pix_rd_en is high for exactly 128 cycles in total.
- pixel[i] = 255 for odd i, 0 for even i -> mean 127, hash_value = 0xAAAAAAAAAAAAAAAA. Then all pixels = 255 -> sum 16320 (no overflow), mean 255, hash 0.
- Three consecutive images, second hash_start pulsed mid-SUM of the first -> ignored, exactly 3 done pulses with hash_img_idx 0,1,2. Then idx_clear + hash_start in the same cycle -> next hash_img_idx = 0.
- Reset asserted in the 10th CMP cycle -> next edge: busy=0, pix_rd_en=0, hash_value=0, no hash_calc_done. A fresh hash_start afterwards completes normally with hash_img_idx = 0.
